// File: rtl/wb_data_arbiter.sv
// Round-robin arbiter for the shared Wishbone data port: N masters, one slave, bounded locking, no-ack timeout.
// One-cycle grant decision; each transfer ends in a one-cycle GAP so the slave's registered ack can drop.
module wb_data_arbiter #(
  parameter int N        = 3,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    m_cyc_i,
  input  logic [N-1:0]    m_stb_i,
  input  logic [N-1:0]    m_we_i,
  input  logic [N*DW-1:0] m_adr_i,
  input  logic [N*DW-1:0] m_dat_i,
  output logic [N-1:0]    m_ack_o,
  output logic [N-1:0]    m_err_o,
  output logic [DW-1:0]   m_dat_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic            s_ack_i,
  input  logic [DW-1:0]   s_dat_i,
  output logic [N-1:0]    gnt_o,
  output logic            busy_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] gidx;
  logic [IW-1:0] last;
  logic [HW-1:0] hold;
  logic [TW-1:0] tmo;

  logic [N-1:0]  req;
  logic [IW-1:0] pick;
  logic [IW-1:0] idx;
  logic          found;
  logic          cyc_g;
  logic          stb_g;
  logic          tmo_hit;

  assign req     = m_cyc_i & m_stb_i;
  assign cyc_g   = |(m_cyc_i & gnt_o);
  assign stb_g   = |(m_stb_i & gnt_o);
  assign tmo_hit = (tmo == TW'(TIMEOUT));

  // Search starts just after the last owner, wrapping modulo N.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Grant is one-hot and zero in IDLE, so an OR-mux yields zeros when idle.
  always_comb begin
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_o[i]) begin
        s_we_o  = s_we_o | m_we_i[i];
        s_adr_o = s_adr_o | m_adr_i[i*DW +: DW];
        s_dat_o = s_dat_o | m_dat_i[i*DW +: DW];
      end
    end
  end

  assign s_stb_o = (state == REQ);
  assign s_cyc_o = (state == REQ) || ((state == GAP) && cyc_g);
  assign busy_o  = (state != IDLE);
  assign m_dat_o = s_dat_i;
  assign m_ack_o = ((state == REQ) && s_ack_i) ? gnt_o : '0;
  assign m_err_o = ((state == REQ) && !s_ack_i && cyc_g && tmo_hit) ? gnt_o : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt_o <= '0;
      gidx  <= '0;
      last  <= IW'(N - 1);
      hold  <= '0;
      tmo   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt_o <= N'(1) << pick;
            gidx  <= pick;
            hold  <= '0;
            tmo   <= '0;
            state <= REQ;
          end
        end
        REQ: begin
          if (s_ack_i) begin
            hold  <= hold + 1'b1;
            state <= GAP;
          end else if (!cyc_g) begin
            state <= GAP;
          end else if (tmo_hit) begin
            // A timed-out master loses its lock so the others are not stalled behind it.
            hold  <= HW'(MAX_HOLD);
            state <= GAP;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        GAP: begin
          if (cyc_g && (hold < HW'(MAX_HOLD))) begin
            if (stb_g) begin
              tmo   <= '0;
              state <= REQ;
            end
          end else begin
            last  <= gidx;
            gnt_o <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
